// File: rtl/cordic_vec_12b_if.sv
// Vector-in / polar-out handshake bundle for cordic_vec_12b.
// Handshake: a transfer happens on a rising edge where valid && ready; the source holds its data stable while valid && !ready.
interface cordic_vec_12b_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   mag_out;
  logic [WIDTH-1:0] angle_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag_out, angle_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag_out, angle_out
  );
endinterface

// File: rtl/cordic_vec_12b.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (magnitude, atan2 phase), one vector in flight.
// Define CORDIC_GAIN_COMP_EN to add a SCALE step that removes the CORDIC gain from the magnitude.
module cordic_vec_12b #(
  parameter int WIDTH = 12,
  parameter int ITERS = 11
) (
  input  logic              clk,
  input  logic              reset,
  cordic_vec_12b_if.slave   bus,
  output logic [1:0]        dbg_state_o
);
  localparam int XW = WIDTH + 2;
  localparam int IW = $clog2(ITERS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [1:0] S_SCALE = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0]    I_LAST = IW'(ITERS - 1);
  localparam logic [WIDTH-1:0] Z_PI2  = WIDTH'(1) << (WIDTH - 2);
  localparam logic [WIDTH-1:0] Z_3PI2 = WIDTH'(3) << (WIDTH - 2);

  logic [1:0]              state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]        z_q, z_d;
  logic [IW-1:0]           i_q, i_d;
  logic                    zero_q, zero_d;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH:0]          mag_q, mag_d;
  logic [WIDTH-1:0]        angle_q, angle_d;

  logic                    in_ready_w;
  logic signed [XW-1:0]    x_in_s, y_in_s, x_sh, y_sh, x_rot, y_rot;
  logic [WIDTH-1:0]        z_rot, atan_i;
`ifdef CORDIC_GAIN_COMP_EN
  logic signed [XW-1:0]    x_scaled;
`endif

  // atan(2^-i) in angle units of 2^WIDTH per turn
  function automatic logic [WIDTH-1:0] atan_lut(input logic [IW-1:0] k);
    logic [11:0] v;
    case (int'(k))
      0:       v = 12'h200;
      1:       v = 12'h12E;
      2:       v = 12'h0A0;
      3:       v = 12'h051;
      4:       v = 12'h029;
      5:       v = 12'h014;
      6:       v = 12'h00A;
      7:       v = 12'h005;
      8:       v = 12'h003;
      9:       v = 12'h001;
      default: v = 12'h000;
    endcase
    return WIDTH'(v);
  endfunction

  assign x_in_s = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
  assign y_in_s = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign atan_i = atan_lut(i_q);

  // Steer toward y = 0; x and y update simultaneously from the old values
  always_comb begin
    if (!y_q[XW-1]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_i;
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_i;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  assign x_scaled = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
`endif

  assign in_ready_w = (state_q == S_IDLE) && !reset;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    mag_d       = mag_q;
    angle_d     = angle_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          // Fold the left half-plane into the right so the iterations converge
          if (!bus.x_in[WIDTH-1]) begin
            x_d = x_in_s;
            y_d = y_in_s;
            z_d = '0;
          end else if (!bus.y_in[WIDTH-1]) begin
            x_d = y_in_s;
            y_d = -x_in_s;
            z_d = Z_PI2;
          end else begin
            x_d = -y_in_s;
            y_d = x_in_s;
            z_d = Z_3PI2;
          end
          zero_d  = (bus.x_in == '0) && (bus.y_in == '0);
          i_d     = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + IW'(1);
        if (i_q == I_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_SCALE;
`else
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          mag_d       = zero_q ? '0 : x_rot[WIDTH:0];
          angle_d     = zero_q ? '0 : z_rot;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_SCALE: begin
        x_d         = x_scaled;
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        mag_d       = zero_q ? '0 : x_scaled[WIDTH:0];
        angle_d     = zero_q ? '0 : z_q;
      end
`endif
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      angle_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      mag_q       <= mag_d;
      angle_q     <= angle_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.mag_out   = mag_q;
  assign bus.angle_out = angle_q;
  assign dbg_state_o   = state_q;
endmodule
